// File: rtl/pe_result_drain.sv
// Collects one result per PE on the rising edge of its done flag, then streams the full frame out row-major over valid/ready.
// Optional NPU_DRAIN_SAT8_EN: output words are unsigned-saturated to 8 bits; stored results keep full width.
module pe_result_drain #(
  parameter int N    = 2,
  parameter int ROWS = 2,
  parameter int COLS = 2,
  localparam int RW  = N + 15,
  localparam int P   = ROWS * COLS,
  localparam int IW  = (P > 1) ? $clog2(P) : 1,
`ifdef NPU_DRAIN_SAT8_EN
  localparam int OW  = 8
`else
  localparam int OW  = RW
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P*RW-1:0] pe_out,
  input  logic [P-1:0]    pe_done,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_last,
  output logic            busy,
  output logic            overrun,
  output logic [15:0]     frame_count
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [P-1:0]  done_q, done_d;
  logic [P-1:0]  captured_q, captured_d;
  logic [P-1:0]  done_rise;
  logic [RW-1:0] result_q [P];
  logic [RW-1:0] result_d [P];
  logic [IW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic [IW-1:0] out_index_q, out_index_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   frame_count_q, frame_count_d;

  function automatic logic [OW-1:0] fmt_word(input logic [RW-1:0] v);
`ifdef NPU_DRAIN_SAT8_EN
    fmt_word = (v > RW'(255)) ? 8'hFF : v[7:0];
`else
    fmt_word = v;
`endif
  endfunction

  // Next-state logic for capture, drain sequencing and the output word registers
  always_comb begin
    done_rise     = pe_done & ~done_q;
    done_d        = pe_done;
    state_d       = state_q;
    captured_d    = captured_q;
    overrun_d     = overrun_q;
    idx_d         = idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_index_d   = out_index_q;
    out_last_d    = out_last_q;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;
    for (int k = 0; k < P; k++) begin
      result_d[k] = result_q[k];
    end
    case (state_q)
      ST_COLLECT: begin
        // A second edge on an already-filled slot keeps the first value
        overrun_d  = overrun_q | (|(done_rise & captured_q));
        captured_d = captured_q | done_rise;
        for (int k = 0; k < P; k++) begin
          result_d[k] = (done_rise[k] & ~captured_q[k]) ? pe_out[k*RW +: RW] : result_q[k];
        end
        if (&captured_q) begin
          state_d     = ST_DRAIN;
          idx_d       = '0;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          out_index_d = '0;
          out_data_d  = fmt_word(result_q[0]);
          out_last_d  = (P == 1);
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        overrun_d = overrun_q | (|done_rise);
        if (out_valid_q & out_ready) begin
          if (out_last_q) begin
            state_d       = ST_COLLECT;
            captured_d    = '0;
            frame_count_d = frame_count_q + 16'd1;
            idx_d         = '0;
            out_valid_d   = 1'b0;
            busy_d        = 1'b0;
            out_index_d   = '0;
            out_data_d    = '0;
            out_last_d    = 1'b0;
          end else begin
            idx_d       = idx_q + IW'(1);
            out_index_d = idx_d;
            out_data_d  = fmt_word(result_q[idx_d]);
            out_last_d  = (idx_d == IW'(P - 1));
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_COLLECT;
      done_q        <= '0;
      captured_q    <= '0;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
      for (int k = 0; k < P; k++) begin
        result_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      captured_q    <= captured_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_index_q   <= out_index_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      for (int k = 0; k < P; k++) begin
        result_q[k] <= result_d[k];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain (2x2 grid, N=2): capture order, simultaneous capture, back-pressure, overrun, reset, level hold.
module tb_pe_result_drain;

`ifdef NPU_DRAIN_SAT8_EN
  localparam int OW = 8;
`else
  localparam int OW = 17;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [67:0]   pe_out;
  logic [3:0]    pe_done;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [1:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          overrun;
  logic [15:0]   frame_count;

  int errors = 0;
  int checks = 0;

  pe_result_drain #(.N(2), .ROWS(2), .COLS(2)) dut (
    .clk(clk), .rst(rst), .pe_out(pe_out), .pe_done(pe_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [16:0] v);
`ifdef NPU_DRAIN_SAT8_EN
    exp_word = (v > 17'd255) ? 32'd255 : 32'(v[7:0]);
`else
    exp_word = 32'(v);
`endif
  endfunction

  task automatic set_vals(input logic [16:0] a, input logic [16:0] b,
                          input logic [16:0] c, input logic [16:0] d);
    pe_out = {d, c, b, a};
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [16:0] v);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_busy"},  32'(busy),      32'd1);
    chk({tag, "_index"}, 32'(out_index), 32'(idx));
    chk({tag, "_data"},  32'(out_data),  exp_word(v));
    chk({tag, "_last"},  32'(out_last),  32'(idx == 3));
  endtask

  task automatic drain_ready(input string tag, input logic [16:0] a, input logic [16:0] b,
                             input logic [16:0] c, input logic [16:0] d);
    logic [16:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_word($sformatf("%s_w%0d", tag, i), i, v[i]);
      step();
    end
    chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_end_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    logic       rdy_seq [7];
    int         idx_seq [7];
    logic [16:0] bp_vals [4];

    rst = 1'b0; pe_done = 4'h0; out_ready = 1'b1; pe_out = '0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);
    chk("rst_fc",    32'(frame_count), 32'd0);

    // basic frame, done order 3,0,2,1
    rst = 1'b1;
    set_vals(17'd1, 17'd2, 17'd3, 17'd4);
    pe_done = 4'b1000; step();
    pe_done = 4'b1001; step();
    pe_done = 4'b1101; step();
    chk("basic_partial_valid", 32'(out_valid), 32'd0);
    pe_done = 4'b1111; step();
    chk("basic_lastcap_valid", 32'(out_valid), 32'd0);
    chk("basic_lastcap_busy",  32'(busy),      32'd0);
    step();
    drain_ready("basic", 17'd1, 17'd2, 17'd3, 17'd4);
    chk("basic_fc", 32'(frame_count), 32'd1);

    // level hold: flags stay high, no new frame may start
    step(); step(); step();
    chk("hold_busy",  32'(busy),        32'd0);
    chk("hold_valid", 32'(out_valid),   32'd0);
    chk("hold_fc",    32'(frame_count), 32'd1);
    pe_done = 4'h0; step();

    // all flags rise together
    set_vals(17'd130050, 17'd5, 17'd0, 17'd7);
    pe_done = 4'hF; step();
    chk("simul_cap_valid", 32'(out_valid), 32'd0);
    step();
    drain_ready("simul", 17'd130050, 17'd5, 17'd0, 17'd7);
    chk("simul_fc", 32'(frame_count), 32'd2);
    pe_done = 4'h0; step();

    // back-pressure
    bp_vals[0] = 17'd10; bp_vals[1] = 17'd20; bp_vals[2] = 17'd30; bp_vals[3] = 17'd40;
    rdy_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idx_seq = '{0, 1, 1, 1, 2, 3, 4};
    set_vals(17'd10, 17'd20, 17'd30, 17'd40);
    out_ready = 1'b0;
    pe_done = 4'hF; step(); step();
    chk_word("bp_start", 0, bp_vals[0]);
    for (int i = 0; i < 7; i++) begin
      out_ready = rdy_seq[i];
      step();
      if (idx_seq[i] < 4) begin
        chk_word($sformatf("bp_s%0d", i), idx_seq[i], bp_vals[idx_seq[i]]);
      end else begin
        chk("bp_end_valid", 32'(out_valid), 32'd0);
      end
    end
    chk("bp_fc", 32'(frame_count), 32'd3);
    pe_done = 4'h0; out_ready = 1'b1; step();

    // overrun: PE1 twice during collect, PE0 pulse during drain
    set_vals(17'd12, 17'd11, 17'd13, 17'd14);
    pe_done = 4'b0010; step();
    chk("ovr_first_clean", 32'(overrun), 32'd0);
    pe_done = 4'b0000; set_vals(17'd12, 17'd9, 17'd13, 17'd14); step();
    pe_done = 4'b0010; step();
    chk("ovr_set", 32'(overrun), 32'd1);
    pe_done = 4'b1101; step();
    pe_done = 4'b1100; step();
    chk_word("ovr_w0", 0, 17'd12);
    pe_done = 4'b1101; step();
    chk_word("ovr_w1", 1, 17'd11);
    pe_done = 4'b1100; step();
    chk_word("ovr_w2", 2, 17'd13);
    step();
    chk_word("ovr_w3", 3, 17'd14);
    step();
    chk("ovr_end_valid", 32'(out_valid), 32'd0);
    chk("ovr_fc",     32'(frame_count), 32'd4);
    chk("ovr_sticky", 32'(overrun),     32'd1);

    // reset after two transfers, flags held high through reset
    pe_done = 4'h0; step();
    set_vals(17'd21, 17'd22, 17'd23, 17'd24);
    pe_done = 4'hF; step(); step();
    chk_word("rd_w0", 0, 17'd21);
    step();
    chk_word("rd_w1", 1, 17'd22);
    step();
    chk_word("rd_w2", 2, 17'd23);
    rst = 1'b0; step();
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_data",  32'(out_data),  32'd0);
    chk("rd_index", 32'(out_index), 32'd0);
    chk("rd_last",  32'(out_last),  32'd0);
    chk("rd_busy",  32'(busy),      32'd0);
    chk("rd_ovr",   32'(overrun),   32'd0);
    chk("rd_fc",    32'(frame_count), 32'd0);
    set_vals(17'd31, 17'd32, 17'd33, 17'd34);
    rst = 1'b1; step();
    chk("rd_cap_valid", 32'(out_valid), 32'd0);
    step();
    chk_word("rd2_w0", 0, 17'd31);
    pe_done = 4'b1110; step();
    chk_word("rd2_w1", 1, 17'd32);
    chk("rd2_ovr_clear", 32'(overrun), 32'd0);
    pe_done = 4'hF; step();
    chk_word("rd2_w2", 2, 17'd33);
    chk("rd2_ovr_drain", 32'(overrun), 32'd1);
    step();
    chk_word("rd2_w3", 3, 17'd34);
    step();
    chk("rd2_end_valid", 32'(out_valid), 32'd0);
    chk("rd2_fc", 32'(frame_count), 32'd1);

    // following frame unaffected by the dropped pulse
    pe_done = 4'h0; step();
    set_vals(17'd41, 17'd42, 17'd43, 17'd44);
    pe_done = 4'hF; step(); step();
    drain_ready("next", 17'd41, 17'd42, 17'd43, 17'd44);
    chk("next_fc",  32'(frame_count), 32'd2);
    chk("next_ovr", 32'(overrun),     32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
